// File: rtl/m_ext_pkg.sv
// Shared RV32M definitions for the multiply and divide units:
// op-select encodings, FSM state type and the default operand width.
package m_ext_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] MULSEL_MUL    = 3'b001;
  localparam logic [2:0] MULSEL_MULH   = 3'b010;
  localparam logic [2:0] MULSEL_MULHSU = 3'b011;
  localparam logic [2:0] MULSEL_MULHU  = 3'b100;

  localparam logic [2:0] DIVSEL_DIV    = 3'b001;
  localparam logic [2:0] DIVSEL_DIVU   = 3'b010;
  localparam logic [2:0] DIVSEL_REM    = 3'b011;
  localparam logic [2:0] DIVSEL_REMU   = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } mul_state_t;

  function automatic logic is_mul_op(
    input logic [2:0] sel
  );
    return (sel == MULSEL_MUL)
        || (sel == MULSEL_MULH)
        || (sel == MULSEL_MULHSU)
        || (sel == MULSEL_MULHU);
  endfunction

endpackage

// File: rtl/mul_pp_step.sv
// One shift-add step: adds b_mag * (BPC bits of a) into the
// 2*XLEN product at bit position i_pos. Purely combinational.
module mul_pp_step #(
  parameter int XLEN = 32,
  parameter int BPC  = 1
) (
  input  logic [2*XLEN-1:0]        i_prod,
  input  logic [XLEN-1:0]          i_b_mag,
  input  logic [BPC-1:0]           i_a_bits,
  input  logic [$clog2(XLEN)-1:0]  i_pos,
  output logic [2*XLEN-1:0]        o_prod
);
  import m_ext_pkg::*;

  localparam int PRW = 2 * XLEN;
  localparam int PPW = XLEN + BPC;

  logic [PPW-1:0] w_pp;

  assign w_pp = PPW'(i_b_mag) * PPW'(i_a_bits);

  // Never overflows: the running sum is bounded by the exact product.
  assign o_prod = i_prod + (PRW'(w_pp) << i_pos);

endmodule

// File: rtl/multiplier.sv
// Iterative shift-add RV32M multiplier (MUL/MULH/MULHSU/MULHU).
// Ports: clk, rst (async active-low), start, mulsel, a, b -> busy, ready, res.
module multiplier #(
  parameter int XLEN           = m_ext_pkg::XLEN,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      mulsel,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            ready,
  output logic [XLEN-1:0] res
);
  import m_ext_pkg::*;

  localparam int BPC = BITS_PER_CYCLE;
  localparam int N   = XLEN / BPC;
  localparam int CW  = $clog2(N);
  localparam int PW  = $clog2(XLEN);
  localparam int SH  = $clog2(BPC);
  localparam int PRW = 2 * XLEN;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  mul_state_t r_state;
  mul_state_t w_next;

  logic [2:0]      r_op;
  logic            r_neg;
  logic [XLEN-1:0] r_a_mag;
  logic [XLEN-1:0] r_b_mag;
  logic [XLEN-1:0] r_res;
  logic [PRW-1:0]  r_prod;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;

  logic            w_accept;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic [PW-1:0]   w_pos;
  logic [PRW-1:0]  w_step;
  logic [PRW-1:0]  w_fix;

  assign w_accept = start && is_mul_op(mulsel)
                 && ((r_state == IDLE)
                  || (r_state == DONE));

  assign w_a_neg = ((mulsel == MULSEL_MULH)
                 || (mulsel == MULSEL_MULHSU))
                 && a[XLEN-1];
  assign w_b_neg = (mulsel == MULSEL_MULH)
                 && b[XLEN-1];

  // Negating 0x8000_0000 yields itself, read as 2^31 unsigned.
  assign w_a_mag = w_a_neg ? -a : a;
  assign w_b_mag = w_b_neg ? -b : b;

  // Bit position of the digit being retired this step.
  assign w_pos = PW'(LAST - r_cnt) << SH;

  assign w_fix = r_neg ? -r_prod : r_prod;

  mul_pp_step #(
    .XLEN (XLEN),
    .BPC  (BPC)
  ) u_step (
    .i_prod   (r_prod),
    .i_b_mag  (r_b_mag),
    .i_a_bits (r_a_mag[BPC-1:0]),
    .i_pos    (w_pos),
    .o_prod   (w_step)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_accept) w_next = CALC;
      CALC: if (r_cnt == '0) w_next = FIX;
      FIX:  w_next = DONE;
      DONE: w_next = w_accept ? CALC : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op    <= '0;
      r_neg   <= 1'b0;
      r_a_mag <= '0;
      r_b_mag <= '0;
      r_res   <= '0;
      r_prod  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_busy <= (w_next == CALC)
             || (w_next == FIX);
      if (w_accept) begin
        r_op    <= mulsel;
        r_neg   <= w_a_neg ^ w_b_neg;
        r_a_mag <= w_a_mag;
        r_b_mag <= w_b_mag;
        r_prod  <= '0;
        r_cnt   <= LAST;
      end else if (r_state == CALC) begin
        r_prod  <= w_step;
        r_a_mag <= r_a_mag >> BPC;
        r_cnt   <= r_cnt - 1'b1;
      end else if (r_state == FIX) begin
        r_prod <= w_fix;
        r_res  <= (r_op == MULSEL_MUL)
                ? w_fix[XLEN-1:0]
                : w_fix[PRW-1:XLEN];
      end
    end
  end

  assign busy  = r_busy;
  assign ready = (r_state == DONE);
  assign res   = r_res;

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier: directed corners plus
// random ops against a 64-bit arithmetic reference, BPC 1 and 4.
module tb_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start1 = 1'b0;
  logic        start4 = 1'b0;
  logic [2:0]  mulsel = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  logic        busy1;
  logic        ready1;
  logic [31:0] res1;
  logic        busy4;
  logic        ready4;
  logic [31:0] res4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multiplier #(
    .XLEN           (32),
    .BITS_PER_CYCLE (1)
  ) u_dut1 (
    .clk    (clk),
    .rst    (rst),
    .start  (start1),
    .mulsel (mulsel),
    .a      (a),
    .b      (b),
    .busy   (busy1),
    .ready  (ready1),
    .res    (res1)
  );

  multiplier #(
    .XLEN           (32),
    .BITS_PER_CYCLE (4)
  ) u_dut4 (
    .clk    (clk),
    .rst    (rst),
    .start  (start4),
    .mulsel (mulsel),
    .a      (a),
    .b      (b),
    .busy   (busy4),
    .ready  (ready4),
    .res    (res4)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Reference: exact 64-bit product of the operands
  // interpreted per op, then pick the low or high half.
  function automatic logic [31:0] ref_mul(
    input logic [2:0]  op,
    input logic [31:0] x,
    input logic [31:0] y
  );
    logic [63:0] xs, xu, ys, yu, p;
    xs = {{32{x[31]}}, x};
    xu = {32'b0, x};
    ys = {{32{y[31]}}, y};
    yu = {32'b0, y};
    case (op)
      3'b010:  p = xs * ys;
      3'b011:  p = xs * yu;
      default: p = xu * yu;
    endcase
    return (op == 3'b001) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic get_busy(input bit d);
    return d ? busy4 : busy1;
  endfunction

  function automatic logic get_ready(input bit d);
    return d ? ready4 : ready1;
  endfunction

  function automatic logic [31:0] get_res(input bit d);
    return d ? res4 : res1;
  endfunction

  // Call at a falling edge.
  task automatic launch(
    input bit          d,
    input logic [2:0]  op,
    input logic [31:0] x,
    input logic [31:0] y
  );
    start1 = !d;
    start4 = d;
    mulsel = op;
    a      = x;
    b      = y;
  endtask

  // Accept edge, then count edges until ready; ends at the
  // falling edge where ready is seen. noise pokes start in CALC.
  task automatic finish(
    input bit          d,
    input string       tag,
    input logic [31:0] exp,
    input int          exp_lat,
    input bit          noise
  );
    int edges;
    int bcnt;
    edges = 0;
    bcnt  = 0;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    start4 = 1'b0;
    if (get_busy(d)) bcnt++;
    while (!get_ready(d) && edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (noise && edges == 5) begin
        launch(d, 3'b100, $urandom, $urandom);
      end else begin
        start1 = 1'b0;
        start4 = 1'b0;
      end
      if (get_busy(d)) bcnt++;
    end
    chk({tag, " latency"}, 64'(edges), 64'(exp_lat));
    chk({tag, " res"}, 64'(get_res(d)), 64'(exp));
    chk({tag, " busy"}, 64'(bcnt), 64'(exp_lat));
  endtask

  // One cycle after ready: pulse over, result held.
  task automatic tail(
    input bit          d,
    input string       tag,
    input logic [31:0] exp
  );
    @(negedge clk);
    chk({tag, " pulse"}, 64'(get_ready(d)), 64'd0);
    chk({tag, " hold"}, 64'(get_res(d)), 64'(exp));
  endtask

  task automatic run(
    input bit          d,
    input string       tag,
    input logic [2:0]  op,
    input logic [31:0] x,
    input logic [31:0] y,
    input logic [31:0] exp,
    input int          lat
  );
    @(negedge clk);
    launch(d, op, x, y);
    finish(d, tag, exp, lat, 1'b0);
    tail(d, tag, exp);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    int          rc;
    int          bc;
    logic [2:0]  bad [4];

    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst busy", 64'(busy1), 64'd0);
    chk("rst ready", 64'(ready1), 64'd0);
    chk("rst res", 64'(res1), 64'd0);
    chk("rst res4", 64'(res4), 64'd0);
    rst = 1'b1;

    run(0, "mulhu_max", 3'b100, 32'hFFFF_FFFF,
        32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run(0, "mulh_min", 3'b010, 32'h8000_0000,
        32'h8000_0000, 32'h4000_0000, 33);
    run(0, "mul_min", 3'b001, 32'h8000_0000,
        32'h8000_0000, 32'h0000_0000, 33);
    run(0, "mulhsu_m1", 3'b011, 32'hFFFF_FFFF,
        32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    run(0, "mul_m3x7", 3'b001, 32'hFFFF_FFFD,
        32'h0000_0007, 32'hFFFF_FFEB, 33);

    // Back-to-back: second start in the DONE cycle.
    x = $urandom;
    y = $urandom;
    @(negedge clk);
    launch(0, 3'b010, x, y);
    finish(0, "b2b_op1", ref_mul(3'b010, x, y), 33, 1'b0);
    launch(0, 3'b001, 32'd6, 32'd7);
    finish(0, "b2b_op2", 32'h0000_002A, 33, 1'b1);
    tail(0, "b2b_op2", 32'h0000_002A);

    // Reset in the middle of CALC.
    @(negedge clk);
    launch(0, 3'b100, 32'hDEAD_BEEF, 32'h1234_5678);
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst busy", 64'(busy1), 64'd0);
    chk("midrst ready", 64'(ready1), 64'd0);
    chk("midrst res", 64'(res1), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    rc = 0;
    bc = 0;
    repeat (50) begin
      @(negedge clk);
      if (ready1) rc++;
      if (busy1) bc++;
    end
    chk("midrst no ready", 64'(rc), 64'd0);
    chk("midrst no busy", 64'(bc), 64'd0);

    // Illegal op selects are ignored.
    bad[0] = 3'b000;
    bad[1] = 3'b101;
    bad[2] = 3'b110;
    bad[3] = 3'b111;
    foreach (bad[k]) begin
      @(negedge clk);
      launch(0, bad[k], $urandom, $urandom);
      @(negedge clk);
      start1 = 1'b0;
      rc = 0;
      bc = 0;
      repeat (40) begin
        @(negedge clk);
        if (ready1) rc++;
        if (busy1) bc++;
      end
      chk($sformatf("illegal%0d ready", bad[k]),
          64'(rc), 64'd0);
      chk($sformatf("illegal%0d busy", bad[k]),
          64'(bc), 64'd0);
    end

    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(1, 4));
      x  = pick();
      y  = pick();
      run(0, $sformatf("rnd%0d op%0d", i, op), op,
          x, y, ref_mul(op, x, y), 33);
    end

    run(1, "bpc4_mulhu_max", 3'b100, 32'hFFFF_FFFF,
        32'hFFFF_FFFF, 32'hFFFF_FFFE, 9);
    run(1, "bpc4_mulh_min", 3'b010, 32'h8000_0000,
        32'h8000_0000, 32'h4000_0000, 9);
    for (int i = 0; i < 6; i++) begin
      op = 3'($urandom_range(1, 4));
      x  = pick();
      y  = pick();
      run(1, $sformatf("bpc4_rnd%0d op%0d", i, op), op,
          x, y, ref_mul(op, x, y), 9);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
